// File: rtl/digit_pulse_gen_if.sv
// rtl/digit_pulse_gen_if.sv - run/step control and digit-timing outputs of the digit pulse generator
interface digit_pulse_gen_if #(
    parameter int DIGITS = 36,
    parameter int MINORS = 16
);
    localparam int DW = $clog2(DIGITS);
    localparam int MW = $clog2(MINORS);

    logic          run;
    logic          step;
    logic          d0;
    logic          d1;
    logic          d18;
    logic          d35;
    logic [DW-1:0] digit;
    logic [MW-1:0] minor;
    logic          major_start;
    logic          active;

    modport master (
        output run,
        output step,
        input  d0,
        input  d1,
        input  d18,
        input  d35,
        input  digit,
        input  minor,
        input  major_start,
        input  active
    );

    modport slave (
        input  run,
        input  step,
        output d0,
        output d1,
        output d18,
        output d35,
        output digit,
        output minor,
        output major_start,
        output active
    );
endinterface

// File: rtl/digit_pulse_gen.sv
// rtl/digit_pulse_gen.sv - digit pulse generator with minor-cycle counter and run/step control
module digit_pulse_gen #(
    parameter int DIGITS = 36,
    parameter int MINORS = 16
) (
    input logic              clk,
    input logic              rst,
    digit_pulse_gen_if.slave bus
);
    localparam int DW = $clog2(DIGITS);
    localparam int MW = $clog2(MINORS);

    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [MW-1:0] LAST_MINOR = MW'(MINORS - 1);

    localparam logic [1:0] ST_STOPPED  = 2'd0;
    localparam logic [1:0] ST_RUNNING  = 2'd1;
    localparam logic [1:0] ST_STEPPING = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] digit_q, digit_d;
    logic [MW-1:0] minor_q, minor_d;

    logic active;
    logic last_digit;

    assign active     = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
    assign last_digit = (digit_q == LAST_DIGIT);

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        minor_d = minor_q;

        if (active) begin
            if (last_digit) begin
                digit_d = '0;
                minor_d = (minor_q == LAST_MINOR) ? '0 : minor_q + MW'(1);
            end else begin
                digit_d = digit_q + DW'(1);
            end
        end

        case (state_q)
            ST_STOPPED: begin
                if (bus.run) begin
                    state_d = ST_RUNNING;
                end else if (bus.step) begin
                    state_d = ST_STEPPING;
                end
            end
            ST_RUNNING: begin
                if (last_digit && !bus.run) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_STEPPING: begin
                // Further step requests are dropped; only run can extend a step.
                if (last_digit) begin
                    state_d = bus.run ? ST_RUNNING : ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOPPED;
            digit_q <= '0;
            minor_q <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            minor_q <= minor_d;
        end
    end

    // Every output decodes registered state only, so run/step never reach them combinationally.
    assign bus.d0          = active && (digit_q == DW'(0));
    assign bus.d1          = active && (digit_q == DW'(1));
    assign bus.d18         = active && (digit_q == DW'(18));
    assign bus.d35         = active && (digit_q == DW'(35));
    assign bus.major_start = active && (digit_q == '0) && (minor_q == '0);
    assign bus.active      = active;
    assign bus.digit       = digit_q;
    assign bus.minor       = minor_q;
endmodule

// File: tb/tb_digit_pulse_gen.sv
// tb/tb_digit_pulse_gen.sv - directed self-checking bench for digit_pulse_gen
module tb_digit_pulse_gen;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    digit_pulse_gen_if #(.DIGITS(36), .MINORS(16)) bus ();

    digit_pulse_gen #(.DIGITS(36), .MINORS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ms_seen;
        int last_ms;
        int d0_cnt;
        int act_cnt;
        int p0, p1, p18, p35;
        bit wrap_seen;
        bit found;
        logic [3:0] prev_minor;

        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        adv(3);

        chk("reset_active", 32'(bus.active), 32'd0);
        chk("reset_d0", 32'(bus.d0), 32'd0);
        chk("reset_digit", 32'(bus.digit), 32'd0);
        chk("reset_minor", 32'(bus.minor), 32'd0);
        chk("reset_major", 32'(bus.major_start), 32'd0);

        rst = 1'b0;
        adv(2);
        chk("idle_active", 32'(bus.active), 32'd0);

        // Start: d0 one cycle after run is sampled.
        bus.run = 1'b1;
        chk("no_same_cycle_d0", 32'(bus.d0), 32'd0);
        adv(1);
        chk("start_d0", 32'(bus.d0), 32'd1);
        chk("start_active", 32'(bus.active), 32'd1);
        chk("start_major", 32'(bus.major_start), 32'd1);
        adv(1);
        chk("d1_pos", 32'(bus.d1), 32'd1);
        chk("d0_clear", 32'(bus.d0), 32'd0);
        adv(17);
        chk("d18_pos", 32'(bus.d18), 32'd1);
        chk("d18_digit", 32'(bus.digit), 32'd18);
        adv(17);
        chk("d35_pos", 32'(bus.d35), 32'd1);
        adv(1);
        chk("wrap_d0", 32'(bus.d0), 32'd1);
        chk("wrap_minor", 32'(bus.minor), 32'd1);

        // Continuous run over 1200 cycles.
        ms_seen   = 0;
        last_ms   = 0;
        d0_cnt    = 0;
        wrap_seen = 1'b0;
        prev_minor = bus.minor;
        for (int i = 1; i <= 1200; i++) begin
            adv(1);
            if (prev_minor == 4'd15 && bus.minor == 4'd0) wrap_seen = 1'b1;
            prev_minor = bus.minor;
            if (bus.major_start) begin
                if (ms_seen > 0) begin
                    chk("major_period", 32'(i - last_ms), 32'd576);
                    chk("d0_per_major", 32'(d0_cnt), 32'd16);
                end
                ms_seen++;
                last_ms = i;
                d0_cnt  = 0;
            end
            if (bus.d0) d0_cnt++;
        end
        chk("major_count", 32'(ms_seen), 32'd2);
        chk("minor_wrap", 32'(wrap_seen), 32'd1);

        // Run until digit 10 of minor 3, then drop run.
        found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (bus.minor == 4'd3 && bus.digit == 6'd10) begin
                found = 1'b1;
                break;
            end
            adv(1);
        end
        chk("reach_m3_d10", 32'(found), 32'd1);
        bus.run = 1'b0;
        adv(8);
        chk("stop_d18", 32'(bus.d18), 32'd1);
        adv(17);
        chk("stop_d35", 32'(bus.d35), 32'd1);
        chk("stop_d35_active", 32'(bus.active), 32'd1);
        adv(1);
        chk("stopped_active", 32'(bus.active), 32'd0);
        chk("stopped_digit", 32'(bus.digit), 32'd0);
        chk("stopped_minor", 32'(bus.minor), 32'd4);
        adv(5);
        chk("stopped_hold", 32'(bus.minor), 32'd4);
        bus.run = 1'b1;
        adv(1);
        chk("resume_d0", 32'(bus.d0), 32'd1);
        chk("resume_minor", 32'(bus.minor), 32'd4);
        bus.run = 1'b0;
        adv(36);
        chk("resume_stop", 32'(bus.active), 32'd0);
        chk("resume_stop_minor", 32'(bus.minor), 32'd5);

        // Single step with a second step request mid-cycle.
        bus.step = 1'b1;
        adv(1);
        bus.step = 1'b0;
        act_cnt = 0;
        p0 = 0; p1 = 0; p18 = 0; p35 = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.active) break;
            act_cnt++;
            p0  += int'(bus.d0);
            p1  += int'(bus.d1);
            p18 += int'(bus.d18);
            p35 += int'(bus.d35);
            bus.step = (act_cnt == 10);
            adv(1);
        end
        bus.step = 1'b0;
        chk("step_cycles", 32'(act_cnt), 32'd36);
        chk("step_d0", 32'(p0), 32'd1);
        chk("step_d1", 32'(p1), 32'd1);
        chk("step_d18", 32'(p18), 32'd1);
        chk("step_d35", 32'(p35), 32'd1);
        chk("step_minor", 32'(bus.minor), 32'd6);
        adv(3);
        chk("step_not_queued", 32'(bus.active), 32'd0);

        // run and step together: run wins.
        bus.run  = 1'b1;
        bus.step = 1'b1;
        adv(1);
        bus.step = 1'b0;
        chk("both_active", 32'(bus.active), 32'd1);
        adv(36);
        chk("both_past_boundary", 32'(bus.active), 32'd1);
        chk("both_d0", 32'(bus.d0), 32'd1);
        chk("both_minor", 32'(bus.minor), 32'd7);

        // Asynchronous reset at digit 20 of minor 5.
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.minor == 4'd5 && bus.digit == 6'd20) begin
                found = 1'b1;
                break;
            end
            adv(1);
        end
        chk("reach_m5_d20", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_active", 32'(bus.active), 32'd0);
        chk("async_digit", 32'(bus.digit), 32'd0);
        chk("async_minor", 32'(bus.minor), 32'd0);
        chk("async_major", 32'(bus.major_start), 32'd0);
        bus.run = 1'b0;
        adv(2);
        rst = 1'b0;
        adv(3);
        chk("post_rst_active", 32'(bus.active), 32'd0);
        chk("post_rst_minor", 32'(bus.minor), 32'd0);
        bus.run = 1'b1;
        adv(1);
        chk("post_rst_d0", 32'(bus.d0), 32'd1);
        chk("post_rst_major", 32'(bus.major_start), 32'd1);
        bus.run = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
